// File: rtl/univ_counter.sv
// univ_counter: modulo-MODULUS up/down counter with synchronous clear, clamped parallel load,
//   a selectable wrap/saturate mode and a combinational cascade carry.
// Latency: Q and Qwrap are registered, so they update one CP edge after the inputs are sampled.
//   Qcc is combinational from the current Q and inputs.
// Backpressure: none; EN is the only flow control. Qcc is meant to drive the EN of the next stage.
//
// Ports:
//   CP    - clock, all state changes on its rising edge
//   CLR   - synchronous active-high clear (highest priority)
//   EN    - count enable, active-high
//   M     - direction: 1 = up, 0 = down
//   LD    - parallel load, active-low (beats EN)
//   D     - load data, clamped to MODULUS-1
//   Q     - registered count, always within 0..MODULUS-1
//   Qcc   - combinational carry/borrow at terminal count
//   Qwrap - registered one-cycle flag for a wrap or saturation event
module univ_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter bit SAT     = 1'b0
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic             EN,
  input  logic             M,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Qcc,
  output logic             Qwrap
);

  // Terminal count. MODULUS <= 2^WIDTH, so MODULUS-1 always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] TC   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             at_top;
  logic             at_bot;
  logic             term;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_val;

  assign at_top = (Q == TC);
  assign at_bot = (Q == ZERO);

  // Terminal condition for the currently selected direction.
  assign term = M ? at_top : at_bot;

  assign Qcc = EN & LD & term;

  // D > TC is the same test as D >= MODULUS, and stays correct when
  // MODULUS = 2^WIDTH (TC is then all ones and nothing is clamped).
  assign load_val = (D > TC) ? TC : D;

  // Next value on an enabled count. At the terminal value the counter either
  // wraps to the opposite end of the range or holds, so Q never leaves
  // 0..MODULUS-1. With MODULUS = 2^WIDTH the wrap targets match binary overflow.
  always_comb begin
    count_val = Q;
    if (term) begin
      if (SAT) begin
        count_val = Q;
      end else begin
        count_val = M ? ZERO : TC;
      end
    end else begin
      count_val = M ? (Q + ONE) : (Q - ONE);
    end
  end

  always_ff @(posedge CP) begin
    if (CLR) begin
      Q     <= ZERO;
      Qwrap <= 1'b0;
    end else if (!LD) begin
      Q     <= load_val;
      Qwrap <= 1'b0;
    end else if (EN) begin
      Q     <= count_val;
      // Flags both a real wrap and a saturated hold.
      Qwrap <= term;
    end else begin
      Qwrap <= 1'b0;
    end
  end

endmodule
